bus_arbiter: RTL

//   Round-robin arbiter for the shared snoopy bus. It grants exactly one cache

---
 rtl/arbiter_pkg.sv | 12 +
 rtl/round_robin_picker.sv | 37 +++
 rtl/bus_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/arbiter_pkg.sv
// Shared types and defaults for the snoopy-bus round-robin arbiters.
package arbiter_pkg;

  typedef enum logic [1:0] {
    ARBITER_IDLE,
    ARBITER_GRANTED,
    ARBITER_RELEASE
  } ArbiterState;

  localparam int unsigned DEFAULT_MAX_HOLD_CYCLES = 64;

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin winner selection: rotate so the device after
// lastGranted sits at bit 0, priority-encode, then rotate the index back.
module round_robin_picker #(
  parameter int unsigned NUMBER_OF_DEVICES = 4,
  parameter int unsigned ID_WIDTH          = $clog2(NUMBER_OF_DEVICES)
) (
  input  logic [NUMBER_OF_DEVICES-1:0] request,
  input  logic [ID_WIDTH-1:0]          lastGranted,
  output logic [ID_WIDTH-1:0]          winner,
  output logic                         anyRequest
);

  localparam int unsigned SUM_WIDTH = ID_WIDTH + 1;

  logic [2*NUMBER_OF_DEVICES-1:0] doubled;
  logic [NUMBER_OF_DEVICES-1:0]   rotated;
  logic [ID_WIDTH-1:0]            offset;
  logic [SUM_WIDTH-1:0]           shift;
  logic [SUM_WIDTH-1:0]           sum;

  // Offset search runs high-to-low so the lowest set bit wins.
  always_comb begin
    doubled = {request, request};
    shift   = {1'b0, lastGranted} + SUM_WIDTH'(1);
    rotated = NUMBER_OF_DEVICES'(doubled >> shift);
    offset  = '0;
    for (int i = int'(NUMBER_OF_DEVICES) - 1; i >= 0; i--) begin
      if (rotated[i]) offset = ID_WIDTH'(i);
    end
    sum = shift + {1'b0, offset};
    if (sum >= SUM_WIDTH'(NUMBER_OF_DEVICES)) sum = sum - SUM_WIDTH'(NUMBER_OF_DEVICES);
  end

  assign winner     = sum[ID_WIDTH-1:0];
  assign anyRequest = |request;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a mandatory dead cycle between owners and a
// hold-limit counter that preempts an owner while others are waiting.
module bus_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned NUMBER_OF_DEVICES = 4,
  parameter int unsigned ID_WIDTH          = $clog2(NUMBER_OF_DEVICES),
  parameter int unsigned MAX_HOLD_CYCLES   = DEFAULT_MAX_HOLD_CYCLES
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUMBER_OF_DEVICES-1:0] request,
  output logic [NUMBER_OF_DEVICES-1:0] grant,
  output logic                         busy,
  output logic [ID_WIDTH-1:0]          grantedId
);

  localparam int unsigned HOLD_WIDTH = (MAX_HOLD_CYCLES > 0) ? $clog2(MAX_HOLD_CYCLES + 1) : 1;
  localparam int unsigned HOLD_LAST  = (MAX_HOLD_CYCLES > 0) ? MAX_HOLD_CYCLES - 1 : 0;

  ArbiterState                  state_q, state_d;
  logic [NUMBER_OF_DEVICES-1:0] grant_q, grant_d;
  logic                         busy_q, busy_d;
  logic [ID_WIDTH-1:0]          granted_id_q, granted_id_d;
  logic [ID_WIDTH-1:0]          last_granted_q, last_granted_d;
  logic [HOLD_WIDTH-1:0]        hold_q, hold_d;

  logic [ID_WIDTH-1:0]          winner;
  logic                         any_request;
  logic [NUMBER_OF_DEVICES-1:0] owner_mask;
  logic                         others_waiting;
  logic                         hold_at_limit;

  round_robin_picker #(
    .NUMBER_OF_DEVICES(NUMBER_OF_DEVICES),
    .ID_WIDTH         (ID_WIDTH)
  ) u_picker (
    .request    (request),
    .lastGranted(last_granted_q),
    .winner     (winner),
    .anyRequest (any_request)
  );

  assign owner_mask     = NUMBER_OF_DEVICES'(1) << granted_id_q;
  assign others_waiting = |(request & ~owner_mask);
  assign hold_at_limit  = (MAX_HOLD_CYCLES != 0) && (hold_q == HOLD_WIDTH'(HOLD_LAST));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ARBITER_IDLE;
      grant_q        <= '0;
      busy_q         <= 1'b0;
      granted_id_q   <= '0;
      last_granted_q <= ID_WIDTH'(NUMBER_OF_DEVICES - 1);
      hold_q         <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      busy_q         <= busy_d;
      granted_id_q   <= granted_id_d;
      last_granted_q <= last_granted_d;
      hold_q         <= hold_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    busy_d         = busy_q;
    granted_id_d   = granted_id_q;
    last_granted_d = last_granted_q;
    hold_d         = hold_q;
    case (state_q)
      ARBITER_IDLE, ARBITER_RELEASE: begin
        if (any_request) begin
          grant_d        = NUMBER_OF_DEVICES'(1) << winner;
          busy_d         = 1'b1;
          granted_id_d   = winner;
          last_granted_d = winner;
          hold_d         = '0;
          state_d        = ARBITER_GRANTED;
        end else begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ARBITER_IDLE;
        end
      end
      ARBITER_GRANTED: begin
        // A voluntary release takes precedence over hitting the hold limit.
        if (!request[granted_id_q] || (hold_at_limit && others_waiting)) begin
          grant_d = '0;
          busy_d  = 1'b0;
          state_d = ARBITER_RELEASE;
        end else if (hold_q != HOLD_WIDTH'(HOLD_LAST)) begin
          hold_d = hold_q + HOLD_WIDTH'(1);
        end
      end
      default: begin
        grant_d = '0;
        busy_d  = 1'b0;
        state_d = ARBITER_IDLE;
      end
    endcase
  end

  assign grant     = grant_q;
  assign busy      = busy_q;
  assign grantedId = granted_id_q;

  a_grant_onehot0: assert property (@(posedge clock) disable iff (reset) $onehot0(grant_q));
  a_no_grant_in_release: assert property (@(posedge clock) disable iff (reset)
    (state_q == ARBITER_RELEASE) |-> (grant_q == '0));

  for (genvar g = 0; g < int'(NUMBER_OF_DEVICES); g++) begin : g_grant_chk
    a_grant_had_request: assert property (@(posedge clock) disable iff (reset)
      grant_q[g] |-> $past(request[g]));
  end

endmodule
